shared_bus_keeper: RTL

Parametrised multi-driver bus resolver for a WIDTH-bit shared signal driven bit-wise by CHANNELS independent sub-blocks, each with per-bit enables. The block resolves drivers once per cycle, holds the last driven value on undriven bits (keeper), records per-bit ownership, and flags contention with sticky flags, a saturating counter and a threshold interrupt. It replaces ad-hoc partial assigns to one shared wire from several generate scopes with a registered, checkable structure.

---
 rtl/shared_bus_pkg.sv | 28 ++
 rtl/shared_bus_bit_resolver.sv | 21 ++
 rtl/shared_bus_keeper.sv | 68 ++++++
 3 files changed

// File: rtl/shared_bus_pkg.sv
// shared_bus_pkg: shared types and the single-bit driver resolution function for shared_bus_keeper.
package shared_bus_pkg;
  localparam int MAX_CH = 32;
  localparam int IDX_MAX_W = 5;
  typedef enum logic {IDLE, ALARM} irq_state_t;
  typedef struct packed {
    logic any;
    logic value;
    logic conflict;
    logic [IDX_MAX_W-1:0] idx;
  } res_t;
  function automatic int cidx_w(input int n);
    return n <= 1 ? 1 : $clog2(n);
  endfunction
  // Scanning downward leaves the lowest enabled channel as winner.
  function automatic res_t resolve(input logic [MAX_CH-1:0] en, input logic [MAX_CH-1:0] val);
    res_t r;
    r = '0;
    for (int i = MAX_CH - 1; i >= 0; i--)
      if (en[i]) begin
        r.idx = IDX_MAX_W'(i);
        r.value = val[i];
      end
    r.any = |en;
    r.conflict = (|(en & val)) && (|(en & ~val));
    return r;
  endfunction
endpackage

// File: rtl/shared_bus_bit_resolver.sv
// shared_bus_bit_resolver: combinational resolution of all channel drivers for one bus bit.
module shared_bus_bit_resolver
  import shared_bus_pkg::*;
#(
  parameter int CHANNELS = 4,
  localparam int CIDX_W = cidx_w(CHANNELS)
) (
  input  logic [CHANNELS-1:0] en,
  input  logic [CHANNELS-1:0] val,
  output logic                any,
  output logic                value,
  output logic                conflict,
  output logic [CIDX_W-1:0]   idx
);
  res_t r;
  assign r = resolve(MAX_CH'(en), MAX_CH'(val));
  assign any = r.any;
  assign value = r.value;
  assign conflict = r.conflict;
  assign idx = CIDX_W'(r.idx);
endmodule

// File: rtl/shared_bus_keeper.sv
// shared_bus_keeper: registered multi-driver bus resolver with keeper, ownership tracking
// and contention flags, saturating counter and threshold interrupt.
module shared_bus_keeper
  import shared_bus_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int WIDTH = 4,
  parameter int CNT_W = 8,
  parameter int THRESH = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int CIDX_W = cidx_w(CHANNELS)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [CHANNELS*WIDTH-1:0]  drv_en,
  input  logic [CHANNELS*WIDTH-1:0]  drv_val,
  input  logic                       clr,
  output logic [WIDTH-1:0]           bus_q,
  output logic [WIDTH-1:0]           bus_valid,
  output logic [WIDTH*CIDX_W-1:0]    owner,
  output logic [WIDTH-1:0]           conflict,
  output logic [CNT_W-1:0]           conflict_cnt,
  output logic                       irq
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] THR = CNT_W'(THRESH);
  logic [CHANNELS-1:0] en_bit [WIDTH];
  logic [CHANNELS-1:0] val_bit [WIDTH];
  logic [CIDX_W-1:0] idx_v [WIDTH];
  logic [WIDTH-1:0] any_v, value_v, conf_v;
  logic [CNT_W-1:0] cnt_next;
  irq_state_t state;
  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      assign en_bit[b][c] = drv_en[c*WIDTH+b];
      assign val_bit[b][c] = drv_val[c*WIDTH+b];
    end
    shared_bus_bit_resolver #(.CHANNELS(CHANNELS)) u_res (
      .en(en_bit[b]), .val(val_bit[b]), .any(any_v[b]), .value(value_v[b]),
      .conflict(conf_v[b]), .idx(idx_v[b])
    );
  end
  // A clear in a contention cycle restarts the count at one so the event is not lost.
  always_comb
    cnt_next = clr ? CNT_W'(|conf_v) :
               (|conf_v && conflict_cnt != CNT_MAX) ? conflict_cnt + 1'b1 : conflict_cnt;
  assign irq = state == ALARM;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_q <= RESET_VAL;
      bus_valid <= '0;
      owner <= '0;
      conflict <= '0;
      conflict_cnt <= '0;
      state <= IDLE;
    end else begin
      for (int b = 0; b < WIDTH; b++)
        if (any_v[b]) begin
          bus_q[b] <= value_v[b];
          owner[b*CIDX_W +: CIDX_W] <= idx_v[b];
        end
      bus_valid <= any_v;
      conflict <= clr ? conf_v : conflict | conf_v;
      conflict_cnt <= cnt_next;
      state <= (cnt_next >= THR) ? ALARM : (clr ? IDLE : state);
    end
  end
endmodule
